// File: rtl/reg_bank_8w.sv
// ---------------------------------------------------------------------------
// reg_bank_8w
//
// Eight-entry register bank at the writeback/decode boundary of the pipelined
// CPU. Writes arrive as a one-hot select vector straight from the 3-to-8
// write-address decoder. Two combinational read ports, optionally forwarding
// a same-cycle write. A pending-write scoreboard marks registers whose
// producer has issued but not yet written back, so decode can stall
// dependent reads.
//
// Parameters
//   WIDTH   data width of each register and of the data ports
//   BYPASS  1: a same-cycle legal write is forwarded to a matching read port
//           and clears that port's hazard in the same cycle
//           0: reads return stored contents only
//
// Optional build macro
//   REG_BANK_ZERO7_EN  when defined, register 7 is hardwired zero: writes to
//                      it are dropped silently, it always reads 0 (even under
//                      bypass) and it can never become busy.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   wr_onehot  in   [7:0] one-hot write select, all-zero = no write
//   wr_data    in   [WIDTH-1:0] write data
//   rd_sel_a   in   [2:0] read port A index
//   rd_sel_b   in   [2:0] read port B index
//   rd_data_a  out  [WIDTH-1:0] read port A data (combinational)
//   rd_data_b  out  [WIDTH-1:0] read port B data (combinational)
//   iss_valid  in   producer issue strobe
//   iss_reg    in   [2:0] destination index of the issuing producer
//   busy       out  [7:0] registered scoreboard, bit i = write pending to reg i
//   busy_cnt   out  [3:0] registered population count of busy
//   stall      out  combinational, a read port targets a pending register
//   wr_err     out  sticky flag, a multi-hot write select was seen
// ---------------------------------------------------------------------------
module reg_bank_8w #(
    parameter int WIDTH  = 64,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       wr_onehot,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [2:0]       rd_sel_a,
    input  logic [2:0]       rd_sel_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             iss_valid,
    input  logic [2:0]       iss_reg,
    output logic [7:0]       busy,
    output logic [3:0]       busy_cnt,
    output logic             stall,
    output logic             wr_err
);

    localparam logic BYP = (BYPASS != 0);

    logic [WIDTH-1:0] regs [8];

    logic [3:0] wr_pop;
    logic       wr_valid;
    logic       wr_multi;
    logic [7:0] clr_vec;
    logic [7:0] set_vec;
    logic [7:0] wr_en;
    logic [7:0] busy_nxt;
    logic       hazard_a;
    logic       hazard_b;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    // Classify the decoder output. Exactly one bit set is a real write; more
    // than one means the decoder (or whatever drives it) has gone wrong, and
    // the whole write is dropped rather than guessing which target was meant.
    always_comb begin
        wr_pop   = popcount8(wr_onehot);
        wr_valid = (wr_pop == 4'd1);
        wr_multi = (wr_pop > 4'd1);
    end

    // Scoreboard set/clear vectors and the per-register write enables. The
    // clear vector doubles as the forwarding match, since a legal write is
    // exactly the one-hot that retires a pending producer. With the zero
    // register enabled, reg 7 can never be written or marked busy.
    always_comb begin
        clr_vec = wr_valid ? wr_onehot : 8'h00;
        set_vec = iss_valid ? (8'b1 << iss_reg) : 8'h00;
        wr_en   = clr_vec;
`ifdef REG_BANK_ZERO7_EN
        set_vec[7] = 1'b0;
        wr_en[7]   = 1'b0;
`endif
    end

    // Next scoreboard value. Set is applied after clear so a producer issuing
    // in the same cycle that the previous producer of that register retires
    // keeps the register pending: the new producer supersedes the old one.
    always_comb begin
        busy_nxt = (busy & ~clr_vec) | set_vec;
    end

    // Register storage. Reset clears every entry immediately, regardless of
    // the clock, so a reset mid-write leaves no partial state behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr_en[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // Scoreboard, its population count and the sticky illegal-write flag.
    // busy_cnt is computed from the next busy value so both registers always
    // agree; with only eight bits it tops out at 8 and cannot wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= 8'h00;
            busy_cnt <= 4'd0;
            wr_err   <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= popcount8(busy_nxt);
            if (wr_multi) begin
                wr_err <= 1'b1;
            end
        end
    end

    // Read ports. Each port independently picks up the in-flight write data
    // when forwarding is enabled and its index matches the legal write. The
    // zero register overrides everything, including forwarding.
    always_comb begin
        rd_data_a = regs[rd_sel_a];
        rd_data_b = regs[rd_sel_b];
        if (BYP && clr_vec[rd_sel_a]) begin
            rd_data_a = wr_data;
        end
        if (BYP && clr_vec[rd_sel_b]) begin
            rd_data_b = wr_data;
        end
`ifdef REG_BANK_ZERO7_EN
        if (rd_sel_a == 3'd7) begin
            rd_data_a = '0;
        end
        if (rd_sel_b == 3'd7) begin
            rd_data_b = '0;
        end
`endif
    end

    // Hazard detection uses the registered scoreboard only, so an issue this
    // cycle stalls from the next cycle. With forwarding, a writeback landing
    // this cycle satisfies the read at once and removes the hazard.
    always_comb begin
        hazard_a = busy[rd_sel_a] & ~(BYP & clr_vec[rd_sel_a]);
        hazard_b = busy[rd_sel_b] & ~(BYP & clr_vec[rd_sel_b]);
        stall    = hazard_a | hazard_b;
    end

endmodule
